mfp_ram_b2_arbiter: RTL
=======================

Name: mfp_ram_b2_arbiter

Overview:
- Two-requester arbiter and sequencer for one simple dual-port block RAM instance (registered read, 1-cycle latency, read-before-write on address collision).
- Sits between the RAM and two masters: the AHB-Lite RAM slave (m0) and a secondary engine such as DMA or video (m1).
- Grants one access per cycle with round-robin priority. Supports bounded locked bursts and routes read data back with a valid strobe.

Parameters:
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 12, RAM word-address width
- MAX_LOCK_CYCLES, 16, maximum consecutive granted cycles one master may hold under lock; must be at least 1

Ports:
- HCLK  in  1  clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- m0_req, m1_req  in  1  access request
- m0_lock, m1_lock  in  1  request to keep ownership after the current access
- m0_we, m1_we  in  1  1=write, 0=read
- m0_addr, m1_addr  in  ADDR_WIDTH  word address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_gnt, m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  read data valid (registered)
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data, both driven from ram_q
- ram_data  out  DATA_WIDTH  RAM write data
- ram_write_addr, ram_read_addr  out  ADDR_WIDTH  RAM addresses
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (m0 preferred), lock_cnt=0, m0_rvalid=m1_rvalid=0. Grants are 0 while HRESETn is low. Reset mid-burst or mid-read discards the pending rvalid.
- Handshake: an access completes in the cycle where req=1 and gnt=1. The master holds req/we/addr/wdata stable until granted.
- Write: ram_we=1 with the granted master's addr and wdata in the grant cycle. No response.
- Read: ram_read_addr = granted addr in the grant cycle. rvalid of that master pulses exactly 1 cycle later, with rdata=ram_q.
- When no access is granted: ram_we=0, ram_read_addr/ram_write_addr hold their previous values (registered mux select). No rvalid.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - One requester: it is granted.
  - Both requesting: the master selected by rr_ptr wins; after the grant, rr_ptr points to the other master.
  - Winner with lock=1: go to LOCKn, lock_cnt=1.
- LOCKn:
  - Only master n can be granted; the other master's req is ignored.
  - Each grant increments lock_cnt.
  - Exit to IDLE with rr_ptr = other master when any of these holds:
    - n's lock is sampled low in a grant cycle, or
    - n drops req, or
    - lock_cnt reaches MAX_LOCK_CYCLES.
  - The cycle after exit performs normal IDLE arbitration.
- MAX_LOCK_CYCLES=1: lock is granted one access only, equivalent to no lock.
- Writes and reads in the same cycle from different masters: see Optional Feature. Without it, a single issue per cycle.
- Back-to-back reads by one master: one rvalid per cycle, in order.

Optional Feature:
- Macro: MFP_RAM_ARB_DUAL_ISSUE_EN.
- Defined, IDLE only (not LOCKn): if one master requests a write and the other a read, both are granted in the same cycle, using the write and read ports concurrently.
  - Same-address collision returns the old data, matching RAM read-before-write.
  - rr_ptr is unchanged after a dual issue.
- Undefined: strictly one grant per cycle; logic absent.

Decomposition:
- Package mfp_ram_arb_pkg:
  - state enum (IDLE, LOCK0, LOCK1)
  - master index constants M0=0, M1=1
  - function clog2 for lock_cnt width
- One natural sub-module: mfp_rr_pick2, the combinational 2-way round-robin selector (req0, req1, ptr -> gnt0, gnt1). Instantiated once.

Test Plan:
- Reset: HRESETn=0 with both req=1 -> gnts=0, rvalids=0. Release -> m0 granted first.
- Single master: m0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> m0_rvalid 1 cycle after the read grant, m0_rdata=0xDEADBEEF, m1_rvalid stays 0.
- Contention: both read continuously -> grants alternate m0,m1,m0,m1. Each rvalid goes only to its owner, one cycle late.
- Lock bound: MAX_LOCK_CYCLES=4, m1 holds lock=1 and req=1, m0 req=1 -> m1 gets exactly 4 grants, then m0 is granted next.
- Reset mid-read: HRESETn pulsed low in the cycle after a read grant -> no rvalid appears. FSM is in IDLE afterwards.
- Dual issue (macro defined): m0 writes 0x11 to addr 3 (old 0x22) while m1 reads addr 3 -> both granted; m1_rdata=0x22 next cycle. A later read of addr 3 returns 0x11.

Source files
------------

// File: rtl/mfp_ram_b2_arbiter_pkg.sv
// Shared types, master indices and width helper for the two-master block-RAM arbiter.
// Optional build macro used by the arbiter: MFP_RAM_ARB_DUAL_ISSUE_EN.
package mfp_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/mfp_ram_b2_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: ptr names the master that wins a tie.
module mfp_rr_pick2
    import mfp_ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 && (!req1 || (ptr == M0));
        gnt1 = req1 && (!req0 || (ptr == M1));
    end

endmodule

// File: rtl/mfp_ram_b2_arbiter.sv
// Round-robin arbiter/sequencer sharing one simple dual-port block RAM between two masters,
// with bounded locked bursts. Define MFP_RAM_ARB_DUAL_ISSUE_EN to allow write+read dual issue in IDLE.
module mfp_ram_b2_arbiter
    import mfp_ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned MAX_LOCK_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_lock,
    input  logic                  m1_lock,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [DATA_WIDTH-1:0] m1_wdata,

    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int unsigned      CNT_W   = clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK_CYCLES);
    localparam logic             LOCK_EN = (MAX_LOCK_CYCLES > 1);

    arb_state_e            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d, lock_cnt_inc;

    logic                  pick0, pick1;
    logic                  dual_ok;
    logic                  gnt0, gnt1;
    logic                  wr0, wr1, rd0, rd1;

    logic                  rvalid0_q, rvalid1_q;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    mfp_rr_pick2 u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .ptr  (rr_ptr_q),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

`ifdef MFP_RAM_ARB_DUAL_ISSUE_EN
    assign dual_ok = m0_req && m1_req && (m0_we != m1_we);
`else
    assign dual_ok = 1'b0;
`endif

    assign lock_cnt_inc = lock_cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;

        if (HRESETn) begin
            unique case (state_q)
                IDLE: begin
                    // A dual issue leaves the round-robin pointer untouched.
                    if (dual_ok) begin
                        gnt0 = 1'b1;
                        gnt1 = 1'b1;
                    end else if (pick0) begin
                        gnt0     = 1'b1;
                        rr_ptr_d = M1;
                        if (m0_lock && LOCK_EN) begin
                            state_d    = LOCK0;
                            lock_cnt_d = CNT_ONE;
                        end
                    end else if (pick1) begin
                        gnt1     = 1'b1;
                        rr_ptr_d = M0;
                        if (m1_lock && LOCK_EN) begin
                            state_d    = LOCK1;
                            lock_cnt_d = CNT_ONE;
                        end
                    end
                end

                LOCK0: begin
                    if (!m0_req) begin
                        state_d    = IDLE;
                        rr_ptr_d   = M1;
                        lock_cnt_d = '0;
                    end else begin
                        gnt0       = 1'b1;
                        lock_cnt_d = lock_cnt_inc;
                        if (!m0_lock || (lock_cnt_inc == CNT_MAX)) begin
                            state_d    = IDLE;
                            rr_ptr_d   = M1;
                            lock_cnt_d = '0;
                        end
                    end
                end

                LOCK1: begin
                    if (!m1_req) begin
                        state_d    = IDLE;
                        rr_ptr_d   = M0;
                        lock_cnt_d = '0;
                    end else begin
                        gnt1       = 1'b1;
                        lock_cnt_d = lock_cnt_inc;
                        if (!m1_lock || (lock_cnt_inc == CNT_MAX)) begin
                            state_d    = IDLE;
                            rr_ptr_d   = M0;
                            lock_cnt_d = '0;
                        end
                    end
                end

                default: begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    // RAM port steering; unused ports keep their last driven address/data.
    always_comb begin
        wr0     = gnt0 && m0_we;
        wr1     = gnt1 && m1_we;
        rd0     = gnt0 && !m0_we;
        rd1     = gnt1 && !m1_we;

        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;

        if (wr0) begin
            waddr_d = m0_addr;
            wdata_d = m0_wdata;
        end else if (wr1) begin
            waddr_d = m1_addr;
            wdata_d = m1_wdata;
        end

        if (rd0) begin
            raddr_d = m0_addr;
        end else if (rd1) begin
            raddr_d = m1_addr;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= M0;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rd0;
            rvalid1_q  <= rd1;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign m0_gnt         = gnt0;
    assign m1_gnt         = gnt1;
    assign m0_rvalid      = rvalid0_q;
    assign m1_rvalid      = rvalid1_q;
    assign m0_rdata       = ram_q;
    assign m1_rdata       = ram_q;

    assign ram_we         = wr0 || wr1;
    assign ram_write_addr = waddr_d;
    assign ram_data       = wdata_d;
    assign ram_read_addr  = raddr_d;

endmodule
